// File: rtl/gpio_port_if.sv
// Data-memory bus slice seen by the GPIO responder: decoded strobes, write data
// and the read word returned to the read mux.
interface gpio_port_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] WD;
    logic [DATA_WIDTH-1:0] RD;

    modport master (
        output we,
        output re,
        output WD,
        input  RD
    );

    modport slave (
        input  we,
        input  re,
        input  WD,
        output RD
    );
endinterface

// File: rtl/gpio_port.sv
// Memory-mapped GPIO: registered output pins, synchronized and debounced input pins
// with a sticky changed flag returned on the read word.
module gpio_port #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned OUT_WIDTH       = 8,
    parameter int unsigned IN_WIDTH        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_port_if.slave           bus,
    input  logic [IN_WIDTH-1:0]  gpio_in,
    output logic [OUT_WIDTH-1:0] gpio_out,
    output logic                 changed
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {StStable, StCounting} state_e;

    state_e               state_q, state_d;
    logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
    logic [IN_WIDTH-1:0]  cand_q, cand_d;
    logic [IN_WIDTH-1:0]  stable_q, stable_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 changed_q, changed_d;
    logic [OUT_WIDTH-1:0] gpio_out_q, gpio_out_d;
    logic                 commit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StStable;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            stable_q   <= '0;
            cnt_q      <= '0;
            changed_q  <= 1'b0;
            gpio_out_q <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            changed_q  <= changed_d;
            gpio_out_q <= gpio_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStable: begin
                if (sync2_q != stable_q) state_d = StCounting;
            end
            StCounting: begin
                if ((sync2_q == cand_q) && (cnt_q == CntMax)) state_d = StStable;
            end
            default: state_d = StStable;
        endcase
    end

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        commit   = 1'b0;
        unique case (state_q)
            StStable: begin
                if (sync2_q != stable_q) begin
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end
            end
            StCounting: begin
                if (sync2_q != cand_q) begin
                    // Any bounce restarts the full window from the new value.
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end else if (cand_q != stable_q) begin
                    stable_d = cand_q;
                    commit   = 1'b1;
                end
            end
            default: ;
        endcase

        // A commit on the same edge as a read keeps the flag set.
        if (commit)      changed_d = 1'b1;
        else if (bus.re) changed_d = 1'b0;
        else             changed_d = changed_q;

        gpio_out_d = bus.we ? bus.WD[OUT_WIDTH-1:0] : gpio_out_q;
    end

    always_comb begin
        bus.RD                 = '0;
        bus.RD[IN_WIDTH-1:0]   = stable_q;
        bus.RD[DATA_WIDTH-1]   = changed_q;
    end

    assign gpio_out = gpio_out_q;
    assign changed  = changed_q;

    generate
        if (OUT_WIDTH < DATA_WIDTH) begin : g_wd_sink
            logic unused_wd;
            assign unused_wd = ^bus.WD[DATA_WIDTH-1:OUT_WIDTH];
        end
    endgenerate

endmodule
